lsu_sequencer: RTL and testbench

Load/store sequencer between the RV32IM execute stage and `data_memory`; it is the initiator side of the memory's `a`/`wd`/`data_size`/`data_unsigned`/`we`/`rd` interface. It accepts one load or store per valid/ready handshake and issues it to `data_memory`. An aligned access becomes a single memory access. A misaligned access is split into a little-endian sequence of byte accesses, and the load result is reassembled and sign- or zero-extended internally.

---
 rtl/lsu_pkg.sv | 48 ++++
 rtl/lsu_sequencer_extend.sv | 27 ++
 rtl/lsu_sequencer.sv | 157 +++++++++++++++
 tb/tb_lsu_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store sequencer and its memory bench.
// Size codes match data_memory's data_size port.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } lsu_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic        we;
  } lsu_req_t;

  function automatic logic [2:0] size_bytes(
    input logic [1:0] size
  );
    logic [2:0] nb;
    unique case (size)
      SIZE_BYTE: nb = 3'd1;
      SIZE_HALF: nb = 3'd2;
      default:   nb = 3'd4;
    endcase
    return nb;
  endfunction

  function automatic logic is_misaligned(
    input logic [1:0] lsb,
    input logic [1:0] size
  );
    logic mis;
    unique case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = lsb[0];
      default:   mis = |lsb;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_sequencer_extend.sv
// Sign/zero extension of a byte-assembled load buffer.
// Size 11 behaves as a word and passes the buffer through.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic sb;
  logic sh;

  assign sb = ~uns & raw[7];
  assign sh = ~uns & raw[15];

  always_comb begin
    data = raw;
    unique case (1'b1)
      size == SIZE_BYTE: data = {{24{sb}}, raw[7:0]};
      size == SIZE_HALF: data = {{16{sh}}, raw[15:0]};
      default:           data = raw;
    endcase
  end

endmodule

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: issues aligned accesses directly and splits
// misaligned ones into little-endian byte beats toward data_memory.
module lsu_sequencer
  import lsu_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic        req_we,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic [1:0]  mem_size,
  output logic        mem_unsigned,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  lsu_state_e  state_q;
  lsu_state_e  state_d;
  lsu_req_t    req_q;
  logic [1:0]  cnt_q;
  logic [1:0]  last_q;
  logic        split_q;
  logic        reject_q;
  logic [31:0] buf_q;

  logic [31:0] a_q;
  logic [31:0] wd_q;
  logic [1:0]  size_q;
  logic        uns_q;

  logic        accept;
  logic        misal;
  logic        reject;
  logic        in_access;
  logic        last_beat;
  logic [2:0]  nb;
  logic [1:0]  last_d;
  logic [7:0]  beat_byte;
  logic [31:0] beat_a;
  logic [31:0] beat_wd;
  logic [1:0]  beat_size;
  logic        beat_uns;
  logic [31:0] ext_data;
  logic [31:0] load_data;

  assign req_ready = (state_q != ACCESS);
  assign accept    = req_valid && req_ready;
  assign misal     = is_misaligned(req_addr[1:0], req_size);
  assign reject    = misal && !ALLOW_MISALIGNED;
  assign in_access = (state_q == ACCESS);
  assign last_beat = (cnt_q == last_q);

  // Aligned requests run a single beat; split ones run one per byte.
  assign nb     = size_bytes(req_size);
  assign last_d = (misal && ALLOW_MISALIGNED) ? 2'(nb - 3'd1) : 2'd0;

  assign beat_byte = req_q.wdata[{cnt_q, 3'b000} +: 8];
  assign beat_a    = req_q.addr + {30'd0, cnt_q};
  assign beat_wd   = split_q ? {24'd0, beat_byte} : req_q.wdata;
  assign beat_size = split_q ? SIZE_BYTE : req_q.size;
  assign beat_uns  = split_q ? 1'b1 : req_q.uns;

  // Outside ACCESS the bus holds whatever the last beat drove.
  assign mem_a        = in_access ? beat_a    : a_q;
  assign mem_wd       = in_access ? beat_wd   : wd_q;
  assign mem_size     = in_access ? beat_size : size_q;
  assign mem_unsigned = in_access ? beat_uns  : uns_q;
  assign mem_we       = in_access && req_q.we;

  load_extend u_extend (
    .raw  (buf_q),
    .size (req_q.size),
    .uns  (req_q.uns),
    .data (ext_data)
  );

  assign load_data = split_q ? ext_data : buf_q;

  assign resp_valid      = (state_q == RESP);
  assign resp_misaligned = resp_valid && reject_q;
  assign resp_rdata      =
    (resp_valid && !reject_q && !req_q.we) ? load_data : 32'd0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          state_d = reject ? RESP : ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (last_beat) begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= '0;
      cnt_q    <= 2'd0;
      last_q   <= 2'd0;
      split_q  <= 1'b0;
      reject_q <= 1'b0;
      buf_q    <= 32'd0;
      a_q      <= 32'd0;
      wd_q     <= 32'd0;
      size_q   <= SIZE_WORD;
      uns_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q.addr  <= req_addr;
        req_q.wdata <= req_wdata;
        req_q.size  <= req_size;
        req_q.uns   <= req_unsigned;
        req_q.we    <= req_we;
        cnt_q       <= 2'd0;
        last_q      <= last_d;
        split_q     <= misal && ALLOW_MISALIGNED;
        reject_q    <= reject;
        buf_q       <= 32'd0;
      end else if (in_access) begin
        a_q    <= beat_a;
        wd_q   <= beat_wd;
        size_q <= beat_size;
        uns_q  <= beat_uns;
        if (!last_beat) begin
          cnt_q <= cnt_q + 2'd1;
        end
        if (split_q) begin
          buf_q[{cnt_q, 3'b000} +: 8] <= mem_rd[7:0];
        end else begin
          buf_q <= mem_rd;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Bench for lsu_sequencer: byte-array memory, directed scenarios,
// then random traffic checked against a byte-level reference memory.
module tb_lsu_sequencer;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned, req_we;
  logic        resp_valid, resp_misaligned;
  logic [31:0] resp_rdata;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic [1:0]  mem_size;
  logic        mem_unsigned, mem_we;

  logic        r_req_valid, r_req_ready;
  logic [31:0] r_req_addr, r_req_wdata;
  logic [1:0]  r_req_size;
  logic        r_req_unsigned, r_req_we;
  logic        r_resp_valid, r_resp_misaligned;
  logic [31:0] r_resp_rdata;
  logic [31:0] r_mem_a, r_mem_wd;
  logic [31:0] r_mem_rd = 32'h5A5A_5A5A;
  logic [1:0]  r_mem_size;
  logic        r_mem_unsigned, r_mem_we;

  lsu_sequencer #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_we(req_we),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .mem_we(mem_we),
    .mem_rd(mem_rd)
  );

  lsu_sequencer #(.ALLOW_MISALIGNED(1'b0)) dut_nr (
    .clk(clk), .rst(rst),
    .req_valid(r_req_valid), .req_ready(r_req_ready),
    .req_addr(r_req_addr), .req_wdata(r_req_wdata),
    .req_size(r_req_size), .req_unsigned(r_req_unsigned),
    .req_we(r_req_we),
    .resp_valid(r_resp_valid), .resp_rdata(r_resp_rdata),
    .resp_misaligned(r_resp_misaligned),
    .mem_a(r_mem_a), .mem_wd(r_mem_wd), .mem_size(r_mem_size),
    .mem_unsigned(r_mem_unsigned), .mem_we(r_mem_we),
    .mem_rd(r_mem_rd)
  );

  // data_memory stand-in: 256 bytes, address aliases mod 256.
  logic [7:0] sim_mem [256];
  logic       mem_clr;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) sim_mem[i] <= 8'h00;
    end else if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i < int'(size_bytes(mem_size)))
          sim_mem[8'(mem_a[7:0] + 8'(i))] <= mem_wd[8*i +: 8];
      end
    end
  end

  always_comb begin
    logic [7:0]  a0;
    logic [31:0] raw;
    a0  = mem_a[7:0];
    raw = {sim_mem[a0 + 8'd3], sim_mem[a0 + 8'd2],
           sim_mem[a0 + 8'd1], sim_mem[a0]};
    mem_rd = raw;
    if (mem_size == SIZE_BYTE)
      mem_rd = {{24{~mem_unsigned & raw[7]}}, raw[7:0]};
    else if (mem_size == SIZE_HALF)
      mem_rd = {{16{~mem_unsigned & raw[15]}}, raw[15:0]};
  end

  logic [31:0] we_log [$];
  int          resp_cnt = 0;
  int          r_we_cnt = 0;

  always @(negedge clk) begin
    if (mem_we) we_log.push_back(mem_a);
    if (resp_valid) resp_cnt++;
    if (r_mem_we) r_we_cnt++;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  logic [7:0] ref_mem [256];

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr,
                                           input int nb, input logic uns);
    longint v;
    v = 0;
    for (int i = 0; i < nb; i++)
      v += longint'(ref_mem[8'(addr + 32'(i))]) << (8 * i);
    if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
      v -= (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [31:0] addr, input int nb,
                           input logic [31:0] wd);
    for (int i = 0; i < nb; i++)
      ref_mem[8'(addr + 32'(i))] = wd[8*i +: 8];
  endtask

  task automatic clear_mem();
    mem_clr = 1'b1;
    @(posedge clk); #1;
    mem_clr = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after an edge.
  task automatic issue(input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rdata,
                       output logic mis, output int lat);
    req_valid = 1'b1; req_we = we; req_size = sz;
    req_unsigned = uns; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0; rdata = '0; mis = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      if (resp_valid) begin
        lat = t; rdata = resp_rdata; mis = resp_misaligned;
      end
      @(posedge clk); #1;
      if (lat != 0) break;
    end
  endtask

  logic [31:0] rd;
  logic        mis;
  int          lat;
  int          base;
  int          rc0;

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rvalid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_rmis"}, 32'(resp_misaligned), 32'd0);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_a"}, mem_a, 32'd0);
    chk({tag, "_wd"}, mem_wd, 32'd0);
    chk({tag, "_size"}, 32'(mem_size), 32'd2);
    chk({tag, "_uns"}, 32'(mem_unsigned), 32'd0);
  endtask

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    req_valid = 0; req_addr = 0; req_wdata = 0;
    req_size = 0; req_unsigned = 0; req_we = 0;
    r_req_valid = 0; r_req_addr = 0; r_req_wdata = 0;
    r_req_size = 0; r_req_unsigned = 0; r_req_we = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; mem_clr = 1'b0;
    chk_reset_outputs("rst");

    // aligned store/load
    issue(1, SIZE_WORD, 0, 32'h0, 32'hDEADBEEF, rd, mis, lat);
    chk("al_st_lat", lat, 2);
    chk("al_st_rdata", rd, 0);
    issue(0, SIZE_WORD, 0, 32'h0, 32'h0, rd, mis, lat);
    chk("al_ld_lat", lat, 2);
    chk("al_ld_rdata", rd, 32'hDEADBEEF);

    // misaligned word store
    clear_mem();
    base = we_log.size();
    issue(1, SIZE_WORD, 0, 32'h5, 32'h11223344, rd, mis, lat);
    chk("mis_st_lat", lat, 5);
    chk("mis_st_pulses", we_log.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (base + i < we_log.size())
        chk($sformatf("mis_st_a%0d", i), we_log[base + i], 32'(5 + i));
    issue(0, SIZE_WORD, 0, 32'h4, 32'h0, rd, mis, lat);
    chk("ld4", rd, 32'h22334400);
    issue(0, SIZE_WORD, 0, 32'h8, 32'h0, rd, mis, lat);
    chk("ld8", rd, 32'h00000011);
    issue(0, SIZE_WORD, 0, 32'h5, 32'h0, rd, mis, lat);
    chk("ld5", rd, 32'h11223344);
    chk("ld5_lat", lat, 5);
    chk("ld5_mis", 32'(mis), 0);

    // misaligned half
    clear_mem();
    issue(1, SIZE_HALF, 0, 32'hB, 32'h8001, rd, mis, lat);
    chk("half_st_lat", lat, 3);
    issue(0, SIZE_HALF, 0, 32'hB, 32'h0, rd, mis, lat);
    chk("half_ld_s", rd, 32'hFFFF8001);
    issue(0, SIZE_HALF, 1, 32'hB, 32'h0, rd, mis, lat);
    chk("half_ld_u", rd, 32'h00008001);

    // reject when misalignment is disallowed
    r_req_valid = 1; r_req_we = 0; r_req_size = SIZE_WORD;
    r_req_addr = 32'h2;
    @(posedge clk); #1;
    r_req_valid = 0;
    chk("rej_valid", 32'(r_resp_valid), 1);
    chk("rej_mis", 32'(r_resp_misaligned), 1);
    chk("rej_rdata", r_resp_rdata, 0);
    chk("rej_ready", 32'(r_req_ready), 1);
    @(posedge clk); #1;
    chk("rej_valid_off", 32'(r_resp_valid), 0);
    chk("rej_mis_off", 32'(r_resp_misaligned), 0);
    chk("rej_we_cnt", r_we_cnt, 0);
    chk("rej_mem_a", r_mem_a, 0);
    chk("rej_mem_wd", r_mem_wd, 0);
    chk("rej_mem_size", 32'(r_mem_size), 2);
    chk("rej_mem_uns", 32'(r_mem_unsigned), 0);

    // reset in the middle of a split store
    clear_mem();
    rc0 = resp_cnt;
    req_valid = 1; req_we = 1; req_size = SIZE_WORD;
    req_unsigned = 0; req_addr = 32'h1; req_wdata = 32'hAABBCCDD;
    @(posedge clk); #1;
    req_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk_reset_outputs("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_b1", sim_mem[1], 8'hDD);
    chk("mid_b2", sim_mem[2], 8'hCC);
    chk("mid_b3", sim_mem[3], 8'h00);
    chk("mid_b4", sim_mem[4], 8'h00);
    chk("mid_noresp", resp_cnt - rc0, 0);
    chk_reset_outputs("post_rst");

    // back-to-back: B held valid across A's response
    clear_mem();
    req_valid = 1; req_we = 1; req_size = SIZE_WORD;
    req_unsigned = 0; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_we = 0; req_wdata = 32'h0;
    @(posedge clk); #1;
    chk("b2b_a_valid", 32'(resp_valid), 1);
    chk("b2b_a_ready", 32'(req_ready), 1);
    chk("b2b_a_rdata", resp_rdata, 0);
    @(posedge clk); #1;
    req_valid = 0;
    chk("b2b_b_busy", 32'(resp_valid), 0);
    chk("b2b_b_noready", 32'(req_ready), 0);
    @(posedge clk); #1;
    chk("b2b_b_valid", 32'(resp_valid), 1);
    chk("b2b_b_rdata", resp_rdata, 32'h12345678);
    @(posedge clk); #1;
    chk("b2b_idle", 32'(resp_valid), 0);

    // address wrap at the top of the space
    clear_mem();
    base = we_log.size();
    issue(1, SIZE_WORD, 0, 32'hFFFFFFFE, 32'hCAFEF00D, rd, mis, lat);
    chk("wrap_pulses", we_log.size() - base, 4);
    if (we_log.size() - base == 4) begin
      chk("wrap_a0", we_log[base], 32'hFFFFFFFE);
      chk("wrap_a1", we_log[base + 1], 32'hFFFFFFFF);
      chk("wrap_a2", we_log[base + 2], 32'h00000000);
      chk("wrap_a3", we_log[base + 3], 32'h00000001);
    end
    issue(0, SIZE_WORD, 0, 32'hFFFFFFFE, 32'h0, rd, mis, lat);
    chk("wrap_ld", rd, 32'hCAFEF00D);

    // random traffic against the reference memory
    clear_mem();
    for (int it = 0; it < 120; it++) begin
      logic        we, uns;
      logic [1:0]  sz;
      logic [31:0] addr, wd, exp;
      int          nb, n;
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      addr = 32'($urandom_range(0, 63));
      wd   = $urandom;
      nb   = nbytes(sz);
      n    = (addr % nb == 0) ? 1 : nb;
      exp  = we ? 32'd0 : ref_load(addr, nb, uns);
      if (we) ref_store(addr, nb, wd);
      issue(we, sz, uns, addr, wd, rd, mis, lat);
      chk($sformatf("rnd%0d_lat", it), lat, n + 1);
      chk($sformatf("rnd%0d_rdata", it), rd, exp);
      chk($sformatf("rnd%0d_mis", it), 32'(mis), 0);
    end
    for (int i = 0; i < 72; i++)
      chk($sformatf("mem%0d", i), sim_mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
